grayscale_feeder: RTL and testbench

Frame-based RGB-to-grayscale converter that produces the 8-bit pixel stream the Sobel stage consumes. It pops 24-bit RGB pixels from an upstream FIFO, converts them with integer luma weights in a 2-stage pipeline, and pushes 8-bit gray pixels into the FIFO that feeds the Sobel block. Each `start` processes exactly one WIDTH×HEIGHT frame, then the block pulses `done` and goes idle.

---
 rtl/img_pkg.sv | 33 +++
 rtl/luma_pipe.sv | 36 +++
 rtl/grayscale_feeder.sv | 97 +++++++++
 tb/tb_grayscale_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-path types and constants for the grayscale feeder
// and the Sobel stage that consumes its output.
package img_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feeder_state_t;

  localparam int IMG_WIDTH  = 720;
  localparam int IMG_HEIGHT = 720;

  // Integer luma weights; they sum to 256 so sum>>8 is the gray value.
  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  typedef struct packed {
    logic        v;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } luma_s1_t;

  function automatic logic [15:0] luma_mul(
    input logic [7:0] c,
    input logic [7:0] w
  );
    return {8'd0, c} * {8'd0, w};
  endfunction

endpackage

// File: rtl/luma_pipe.sv
// Two-stage RGB->gray pipeline: stage 1 products, stage 2 sum>>8.
// Ports: clk, rst, advance (shift enable), in_valid, rgb, out_valid, gray.
module luma_pipe
  import img_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        in_valid,
  input  logic [23:0] rgb,
  output logic        out_valid,
  output logic [7:0]  gray
);

  luma_s1_t    s1;
  logic [15:0] sum;

  // Max 255*256 = 65280, so 16 bits never overflow.
  assign sum = s1.pr + s1.pg + s1.pb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      out_valid <= 1'b0;
      gray      <= 8'd0;
    end else if (advance) begin
      s1.v      <= in_valid;
      s1.pr     <= luma_mul(rgb[23:16], LUMA_R);
      s1.pg     <= luma_mul(rgb[15:8], LUMA_G);
      s1.pb     <= luma_mul(rgb[7:0], LUMA_B);
      out_valid <= s1.v;
      gray      <= sum[15:8];
    end
  end

endmodule

// File: rtl/grayscale_feeder.sv
// Frame-based RGB FIFO -> gray FIFO feeder: one WIDTH x HEIGHT frame per start.
// Ports: clk, rst, start, in_rd_en/in_empty/rgb_in, out_wr_en/out_full/gray_out, busy, done.
module grayscale_feeder
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int CNT_W  = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [23:0] rgb_in,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [7:0]  gray_out,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WIDTH * HEIGHT);

  feeder_state_t    state, state_n;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic [CNT_W-1:0] rd_nxt, wr_nxt;
  logic             v2;
  logic             advance;
  logic             clr;
  logic             done_n;

  // A full stage 2 blocked by out_full freezes the whole pipe.
  assign advance   = !v2 || !out_full;
  assign in_rd_en  = (state == RUN) && advance && !in_empty
                     && (rd_cnt < TOTAL);
  assign out_wr_en = v2 && !out_full;
  assign busy      = (state != IDLE);

  // Counts including this cycle's pop/push, for same-cycle exits.
  assign rd_nxt = rd_cnt + CNT_W'(in_rd_en);
  assign wr_nxt = wr_cnt + CNT_W'(out_wr_en);

  luma_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .in_valid  (in_rd_en),
    .rgb       (rgb_in),
    .out_valid (v2),
    .gray      (gray_out)
  );

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (rd_nxt == TOTAL) state_n = DRAIN;
      end
      DRAIN: begin
        if (wr_nxt == TOTAL) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_cnt <= '0;
      wr_cnt <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (clr) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        rd_cnt <= rd_nxt;
        wr_cnt <= wr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_grayscale_feeder.sv
// Self-checking bench for grayscale_feeder with WIDTH=4, HEIGHT=2,
// modelling both FIFOs and the expected gray stream with queues.
module tb_grayscale_feeder;

  localparam int NPIX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_rd_en;
  logic        in_empty;
  logic [23:0] rgb_in;
  logic        out_wr_en;
  logic        out_full;
  logic [7:0]  gray_out;
  logic        busy;
  logic        done;

  grayscale_feeder #(
    .WIDTH  (4),
    .HEIGHT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_rd_en  (in_rd_en),
    .in_empty  (in_empty),
    .rgb_in    (rgb_in),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .gray_out  (gray_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] src[$];
  logic [7:0]  exp_q[$];
  int          pop_cyc[$];
  int          push_cyc[$];
  int          cyc = 0;
  int          pops, pushes, dones, done_cyc, start_cyc;
  bit          fe = 0;
  bit          tog = 0;
  bit          hold = 0;
  logic [7:0]  hold_g;
  logic        s_busy, s_done;

  function automatic logic [7:0] luma(input logic [23:0] p);
    int y;
    y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    return 8'(y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in();
    in_empty = fe || (src.size() == 0);
    rgb_in   = (src.size() != 0) ? src[0] : 24'h0;
  endtask

  task automatic tick();
    logic rd, wr;
    logic [7:0] g;
    logic [23:0] px;
    @(negedge clk);
    rd = in_rd_en; wr = out_wr_en; g = gray_out; px = rgb_in;
    s_busy = busy; s_done = done;
    if (rd) chk("pop_empty", in_empty, 0);
    if (wr) begin
      chk("push_full", out_full, 0);
      chk("push_extra", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("gray", g, exp_q.pop_front());
    end
    if (hold) begin
      chk("hold_rd", rd, 0);
      chk("hold_wr", wr, 0);
      chk("hold_gray", g, hold_g);
    end
    @(posedge clk);
    #1;
    if (rd) begin
      void'(src.pop_front());
      exp_q.push_back(luma(px));
      pop_cyc.push_back(cyc);
      pops++;
    end
    if (wr) begin
      push_cyc.push_back(cyc);
      pushes++;
    end
    if (s_done) begin
      dones++;
      done_cyc = cyc;
    end
    cyc++;
    if (tog) fe = !fe;
    drive_in();
  endtask

  task automatic new_frame();
    pops = 0; pushes = 0; dones = 0;
    pop_cyc.delete(); push_cyc.delete(); exp_q.delete();
  endtask

  task automatic kick();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (s_done) got = 1;
      else chk("busy", s_busy, 1);
    end
    chk("done_seen", 32'(got), 1);
  endtask

  task automatic wait_pushes(input int n, input int budget);
    for (int i = 0; i < budget && pushes < n; i++) begin
      tick();
      chk("busy", s_busy, 1);
    end
    chk("push_reach", 32'(pushes >= n), 1);
  endtask

  task automatic frame_checks();
    chk("pops", pops, NPIX);
    chk("pushes", pushes, NPIX);
    chk("dones", dones, 1);
    chk("lost", exp_q.size(), 0);
    tick();
    chk("done_pulse", s_done, 0);
    chk("idle", s_busy, 0);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) src.push_back(24'($urandom));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_full = 1'b0;
    src.delete();
    for (int i = 0; i < NPIX; i++) src.push_back({8'd200, 8'd200, 8'd200});
    drive_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", in_rd_en, 0);
    chk("rst_wr", out_wr_en, 0);
    chk("rst_gray", gray_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Flat gray frame at full rate: latency and frame timing.
    new_frame();
    kick();
    wait_done(100);
    if (pushes == NPIX && pops == NPIX) begin
      chk("latency", push_cyc[0] - pop_cyc[0], 2);
      chk("pop_burst", pop_cyc[NPIX-1] - pop_cyc[0], NPIX - 1);
      chk("push_burst", push_cyc[NPIX-1] - push_cyc[0], NPIX - 1);
      chk("done_after", done_cyc - push_cyc[NPIX-1], 1);
      chk("frame_time", done_cyc - (start_cyc + 1), NPIX + 2);
    end
    frame_checks();

    // Primary and extreme colours.
    new_frame();
    src.delete();
    src.push_back(24'hFF0000); src.push_back(24'h00FF00);
    src.push_back(24'h0000FF); src.push_back(24'hFFFFFF);
    src.push_back(24'h000000);
    fill_rand(3);
    drive_in();
    kick();
    wait_done(100);
    frame_checks();

    // Downstream full for 5 cycles mid-frame.
    new_frame();
    src.delete();
    fill_rand(NPIX);
    drive_in();
    kick();
    wait_pushes(3, 100);
    out_full = 1'b1;
    hold_g = gray_out;
    hold = 1;
    repeat (5) tick();
    hold = 0;
    out_full = 1'b0;
    wait_done(100);
    frame_checks();

    // Upstream empty every other cycle.
    new_frame();
    src.delete();
    fill_rand(NPIX);
    tog = 1;
    drive_in();
    kick();
    wait_done(200);
    tog = 0;
    fe = 0;
    drive_in();
    frame_checks();

    // Extra words and a stray start during RUN.
    new_frame();
    src.delete();
    fill_rand(NPIX + 4);
    drive_in();
    kick();
    repeat (3) begin
      tick();
      chk("busy", s_busy, 1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    frame_checks();
    repeat (4) tick();
    chk("extra_left", src.size(), 4);
    chk("no_late_pop", pops, NPIX);

    // Reset mid-frame, then a clean frame.
    new_frame();
    src.delete();
    fill_rand(NPIX);
    drive_in();
    kick();
    wait_pushes(3, 100);
    rst = 1'b1;
    #1;
    chk("mrst_rd", in_rd_en, 0);
    chk("mrst_wr", out_wr_en, 0);
    chk("mrst_gray", gray_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    new_frame();
    src.delete();
    fill_rand(NPIX);
    drive_in();
    kick();
    wait_done(100);
    frame_checks();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
